// File: rtl/des_pkg.sv
// des_pkg
//   Shared DES definitions for the iterative encrypt and decrypt datapaths.
//   Contents: FSM state type, permutation tables (IP, FP, E, P, PC1, PC2),
//   the eight S-boxes, the key-schedule shift amounts and the round helpers.
//   Bit numbering: vector bit [W-1] is DES bit 1.
package des_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } des_state_e;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,
        39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,
        37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,
        35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,
        33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Flattened S-boxes: index = box*64 + row*16 + col.
    localparam int SBOX [512] = '{
        14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
        0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
        4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
        15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
        15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
        3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
        0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
        13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
        10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
        1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
        7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
        13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
        3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
        2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
        14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
        4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
        11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
        12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
        10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
        9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
        4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
        4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
        13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
        1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
        6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
        13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
        1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
        7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
        2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11
    };

    // Encrypt key-schedule left shifts, index 0 = round 1.
    localparam int LSHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    // Decrypt right shifts, index 0 = decrypt round 1. Round 1 needs no shift
    // because C16/D16 equals C0/D0; round j then undoes encrypt round 18-j.
    function automatic logic [1:0] dec_rshift(logic [3:0] idx);
        if (idx == 4'd0)
            return 2'd0;
        return 2'(LSHIFT[16 - int'(idx)]);
    endfunction

    function automatic logic [1:0] enc_lshift(logic [3:0] idx);
        return 2'(LSHIFT[int'(idx)]);
    endfunction

    function automatic logic [63:0] permute_ip(logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] permute_fp(logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] permute_pc1(logic [63:0] x);
        logic [55:0] y;
        y = '0;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] permute_pc2(logic [55:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] expand(logic [31:0] x);
        logic [47:0] y;
        y = '0;
        for (int i = 0; i < 48; i++) y[47-i] = x[32-E_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] permute_p(logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 32; i++) y[31-i] = x[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(logic [31:0] r, logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [5:0]  six;
        int          row;
        int          col;
        x = expand(r) ^ k;
        s = '0;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            row = int'({six[5], six[0]});
            col = int'(six[4:1]);
            s[31-4*b -: 4] = 4'(SBOX[b*64 + row*16 + col]);
        end
        return permute_p(s);
    endfunction

    // 28-bit rotate by 0..2; left for encrypt, right for decrypt.
    function automatic logic [27:0] rot28(logic [27:0] x, logic [1:0] amt, logic left);
        case (amt)
            2'd1:    return left ? {x[26:0], x[27]}    : {x[0], x[27:1]};
            2'd2:    return left ? {x[25:0], x[27:26]} : {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_decrypt_iter_round.sv
// des_round
//   One combinational Feistel round including its key-schedule step.
//   i_l/i_r   : half-blocks in;   o_l/o_r : half-blocks out
//   i_c/i_d   : key halves in;    o_c/o_d : rotated key halves out
//   i_shamt   : rotate amount for this round
//   i_mode    : 1 = rotate left (encrypt), 0 = rotate right (decrypt)
//   The rotation is applied before PC2 so the subkey comes from the
//   rotated halves in both directions.
module des_round
    import des_pkg::*;
(
    input  logic [31:0] i_l,
    input  logic [31:0] i_r,
    input  logic [27:0] i_c,
    input  logic [27:0] i_d,
    input  logic [1:0]  i_shamt,
    input  logic        i_mode,
    output logic [31:0] o_l,
    output logic [31:0] o_r,
    output logic [27:0] o_c,
    output logic [27:0] o_d
);

    logic [27:0] w_c;
    logic [27:0] w_d;
    logic [47:0] w_k;

    assign w_c = rot28(i_c, i_shamt, i_mode);
    assign w_d = rot28(i_d, i_shamt, i_mode);
    assign w_k = permute_pc2({w_c, w_d});

    assign o_l = i_r;
    assign o_r = i_l ^ des_f(i_r, w_k);
    assign o_c = w_c;
    assign o_d = w_d;

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter
//   Iterative DES decryption, ROUNDS_PER_CYCLE rounds per clock.
//   clk_i, rst_ni      : clock, async active-low reset
//   valid_i, ready_o   : ciphertext/key handshake (ready_o = idle)
//   block_i, key_i     : ciphertext and key, bit 63 = DES bit 1
//   valid_o, ready_i   : plaintext handshake
//   block_o            : plaintext, held after the handshake
//
//   state | meaning
//   IDLE  | waiting for valid_i; loads IP(block), PC1(key) on handshake
//   ROUND | running rounds, r_cnt = rounds already completed
//   DONE  | plaintext on block_o, waiting for ready_i
module des_decrypt_iter
    import des_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] block_i,
    input  logic [63:0] key_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] block_o
);

    localparam int RPC = ROUNDS_PER_CYCLE;

    if (RPC != 1 && RPC != 2 && RPC != 4 && RPC != 8) begin : g_bad_rpc
        $error("des_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    des_state_e  r_state;
    des_state_e  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [31:0] r_l;
    logic [31:0] r_r;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [63:0] r_block_o;
    logic        w_last;

    logic [31:0] w_l [RPC+1];
    logic [31:0] w_r [RPC+1];
    logic [27:0] w_c [RPC+1];
    logic [27:0] w_d [RPC+1];

    assign w_l[0] = r_l;
    assign w_r[0] = r_r;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [3:0] w_idx;
        assign w_idx = r_cnt + 4'(g);

        des_round u_round (
            .i_l     (w_l[g]),
            .i_r     (w_r[g]),
            .i_c     (w_c[g]),
            .i_d     (w_d[g]),
            .i_shamt (dec_rshift(w_idx)),
            .i_mode  (1'b0),
            .o_l     (w_l[g+1]),
            .o_r     (w_r[g+1]),
            .o_c     (w_c[g+1]),
            .o_d     (w_d[g+1])
        );
    end

    // Counter never wraps: the edge that would take it past 15 is the last.
    assign w_last = (r_cnt == 4'(16 - RPC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (valid_i) w_state_nxt = ROUND;
            ROUND:   if (w_last)  w_state_nxt = DONE;
            DONE:    if (ready_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Inputs are only looked at in IDLE, so X on block_i/key_i elsewhere
    // cannot reach the registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_l       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_block_o <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        {r_l, r_r} <= permute_ip(block_i);
                        {r_c, r_d} <= permute_pc1(key_i);
                        r_cnt      <= '0;
                    end
                end
                ROUND: begin
                    r_l <= w_l[RPC];
                    r_r <= w_r[RPC];
                    r_c <= w_c[RPC];
                    r_d <= w_d[RPC];
                    if (w_last) begin
                        // Halves are swapped before the final permutation.
                        r_block_o <= permute_fp({w_r[RPC], w_l[RPC]});
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'(RPC);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready_o = (r_state == IDLE);
    assign valid_o = (r_state == DONE);
    assign block_o = r_block_o;

endmodule

// File: tb/tb_des_decrypt_iter.sv
module tb_des_decrypt_iter;

    typedef struct {
        logic [63:0] key;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] block_i;
    logic [63:0] key_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] block_o;

    logic        sw_valid;
    logic [63:0] sw_block;
    logic [63:0] sw_key;
    logic        sw_ready;
    logic [2:0]  sw_ready_o;
    logic [2:0]  sw_valid_o;
    logic [63:0] sw_block_o [3];

    int n_checks;
    int n_errors;
    vec_t vecs [6];

    des_decrypt_iter #(.ROUNDS_PER_CYCLE(1)) u_dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .block_i (block_i),
        .key_i   (key_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .block_o (block_o)
    );

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        des_decrypt_iter #(.ROUNDS_PER_CYCLE(2 << g)) u_sw (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .valid_i (sw_valid),
            .ready_o (sw_ready_o[g]),
            .block_i (sw_block),
            .key_i   (sw_key),
            .valid_o (sw_valid_o[g]),
            .ready_i (sw_ready),
            .block_o (sw_block_o[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle.
    task automatic start_blk(input vec_t v);
        chk("ready_before_start", 64'(ready_o), 64'd1);
        valid_i = 1'b1;
        block_i = v.ct;
        key_i   = v.key;
        @(posedge clk); #1;
        valid_i = 1'b0;
        block_i = {$urandom, $urandom};
        key_i   = {$urandom, $urandom};
    endtask

    task automatic wait_valid(output int lat, output bit rdy_low);
        lat = 0;
        rdy_low = 1'b1;
        while (!valid_o && lat < 40) begin
            if (ready_o) rdy_low = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (ready_o) rdy_low = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit rdy_low;
        start_blk(v);
        wait_valid(lat, rdy_low);
        chk({tag, "_latency"}, 64'(lat), 64'd16);
        chk({tag, "_ready_low"}, 64'(rdy_low), 64'd1);
        chk({tag, "_plaintext"}, block_o, v.pt);
        @(posedge clk); #1;
        chk({tag, "_valid_pulse"}, 64'(valid_o), 64'd0);
        chk({tag, "_ready_back"}, 64'(ready_o), 64'd1);
    endtask

    initial begin
        int lat;
        bit rdy_low;
        int hs_cyc [3];
        int out_cyc [3];
        logic [63:0] out_pt [3];
        int vi;
        int no;
        bit rdy_before;
        int sw_lat [3];
        logic [63:0] sw_pt [3];

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{key: 64'h133457799BBCDFF1, ct: 64'h85E813540F0AB405, pt: 64'h0123456789ABCDEF};
        vecs[1] = '{key: 64'h0E329232EA6D0D73, ct: 64'h0000000000000000, pt: 64'h8787878787878787};
        vecs[2] = '{key: 64'h0F339333EB6C0C72, ct: 64'h0000000000000000, pt: 64'h8787878787878787};
        vecs[3] = '{key: 64'h0000000000000000, ct: 64'h8CA64DE9C1B123A7, pt: 64'h0000000000000000};
        vecs[4] = '{key: 64'hFFFFFFFFFFFFFFFF, ct: 64'h7359B2163E4EDC58, pt: 64'hFFFFFFFFFFFFFFFF};
        vecs[5] = '{key: 64'hECCBA8866443200E, ct: 64'h7A17ECABF0F54BFA, pt: 64'hFEDCBA9876543210};

        rst_n    = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        block_i  = '0;
        key_i    = '0;
        sw_valid = 1'b0;
        sw_ready = 1'b1;
        sw_block = '0;
        sw_key   = '0;

        #2;
        chk("reset_ready_o", 64'(ready_o), 64'd1);
        chk("reset_valid_o", 64'(valid_o), 64'd0);
        chk("reset_block_o", block_o, 64'd0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Known-answer table, including the parity-flipped key.
        for (int i = 0; i < 6; i++)
            run_vec(vecs[i], $sformatf("kat%0d", i));

        // Backpressure with input noise while DONE.
        ready_i = 1'b0;
        start_blk(vecs[0]);
        wait_valid(lat, rdy_low);
        chk("bp_latency", 64'(lat), 64'd16);
        chk("bp_plaintext", block_o, vecs[0].pt);
        for (int c = 0; c < 10; c++) begin
            valid_i = ~valid_i;
            block_i = {$urandom, $urandom};
            key_i   = {$urandom, $urandom};
            @(posedge clk); #1;
            chk("bp_hold_valid", 64'(valid_o), 64'd1);
            chk("bp_hold_block", block_o, vecs[0].pt);
            chk("bp_hold_ready", 64'(ready_o), 64'd0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(ready_o), 64'd1);
        chk("bp_release_valid", 64'(valid_o), 64'd0);

        // Asynchronous reset in the middle of round processing.
        start_blk(vecs[0]);
        repeat (7) @(posedge clk);
        #4 rst_n = 1'b0;
        #1;
        chk("midrst_valid_o", 64'(valid_o), 64'd0);
        chk("midrst_ready_o", 64'(ready_o), 64'd1);
        chk("midrst_block_o", block_o, 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vecs[1], "after_rst");

        // Streaming: valid_i held high, vectors 0,1,0.
        vi = 0;
        no = 0;
        valid_i = 1'b1;
        block_i = vecs[0].ct;
        key_i   = vecs[0].key;
        for (int c = 0; c < 70; c++) begin
            rdy_before = ready_o;
            @(posedge clk); #1;
            if (rdy_before && vi < 3) begin
                hs_cyc[vi] = c;
                vi++;
                if (vi < 3) begin
                    block_i = vecs[vi == 1 ? 1 : 0].ct;
                    key_i   = vecs[vi == 1 ? 1 : 0].key;
                end else begin
                    valid_i = 1'b0;
                end
            end
            if (valid_o) begin
                if (no < 3) begin
                    out_cyc[no] = c;
                    out_pt[no]  = block_o;
                end
                no++;
            end
        end
        chk("stream_handshakes", 64'(vi), 64'd3);
        chk("stream_outputs", 64'(no), 64'd3);
        if (no >= 3 && vi >= 3) begin
            chk("stream_pt0", out_pt[0], vecs[0].pt);
            chk("stream_pt1", out_pt[1], vecs[1].pt);
            chk("stream_pt2", out_pt[2], vecs[0].pt);
            chk("stream_latency0", 64'(out_cyc[0] - hs_cyc[0]), 64'd16);
            chk("stream_spacing1", 64'(out_cyc[1] - out_cyc[0]), 64'd18);
            chk("stream_spacing2", 64'(out_cyc[2] - out_cyc[1]), 64'd18);
        end

        // Parameter sweep: 2, 4 and 8 rounds per clock.
        for (int v = 0; v < 2; v++) begin
            for (int g = 0; g < 3; g++) begin
                chk("sweep_ready_idle", 64'(sw_ready_o[g]), 64'd1);
                sw_lat[g] = 0;
                sw_pt[g]  = '0;
            end
            sw_valid = 1'b1;
            sw_block = vecs[v].ct;
            sw_key   = vecs[v].key;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            sw_block = {$urandom, $urandom};
            sw_key   = {$urandom, $urandom};
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                for (int g = 0; g < 3; g++) begin
                    if (sw_valid_o[g] && sw_lat[g] == 0) begin
                        sw_lat[g] = c;
                        sw_pt[g]  = sw_block_o[g];
                    end
                end
            end
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("sweep_rpc%0d_latency", 2 << g), 64'(sw_lat[g]), 64'(8 >> g));
                chk($sformatf("sweep_rpc%0d_pt", 2 << g), sw_pt[g], vecs[v].pt);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
